// File: rtl/npn_tt_sweeper_if.sv
// npn_tt_sweeper_if: request/result bundle between a sweep requester and the
// truth-table sweeper.
//   start, perm[7:0], neg_mask[3:0], out_neg : sweep request and NPN transform
//   busy, err                                : sweeper status
//   tt[15:0], tt_valid, tt_ready             : result handshake
//   tt_ones[4:0]                             : popcount of tt (NPN_TT_ONES_EN only)
// master = requester / consumer side, slave = sweeper side.
interface npn_tt_sweeper_if;
  logic        start;
  logic [7:0]  perm;
  logic [3:0]  neg_mask;
  logic        out_neg;
  logic        busy;
  logic        err;
  logic [15:0] tt;
  logic        tt_valid;
  logic        tt_ready;
`ifdef NPN_TT_ONES_EN
  logic [4:0]  tt_ones;
`endif

  modport master (
    output start, perm, neg_mask, out_neg, tt_ready,
`ifdef NPN_TT_ONES_EN
    input  tt_ones,
`endif
    input  busy, err, tt, tt_valid
  );

  modport slave (
    input  start, perm, neg_mask, out_neg, tt_ready,
`ifdef NPN_TT_ONES_EN
    output tt_ones,
`endif
    output busy, err, tt, tt_valid
  );
endinterface

// File: rtl/npn_tt_sweeper.sv
// npn_tt_sweeper: walks an external 4-input function netlist through all 16
// minterms and collects its output y0 into a 16-bit truth table, applying a
// latched input permutation, input negation and output negation (NPN).
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : npn_tt_sweeper_if.slave (request, status, result handshake)
//   x[3:0]     : drives x0..x3 of the netlist under test (0 when not sweeping)
//   y0         : netlist output, sampled on the last cycle of each minterm
// Parameter SETTLE (0..7): extra wait cycles per minterm before sampling.
// Optional macro NPN_TT_ONES_EN: adds bus.tt_ones, a running count of 1-samples.
module npn_tt_sweeper #(
  parameter int unsigned SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  npn_tt_sweeper_if.slave       bus,
  output logic [3:0]            x,
  input  logic                  y0
);
  localparam logic [2:0] SETTLE_C = 3'(SETTLE);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;
  state_t state, state_nxt;

  logic [3:0]  m;
  logic [2:0]  scnt;
  logic [7:0]  perm_q;
  logic [3:0]  neg_q;
  logic        on_q;
  logic [15:0] tt_q;
  logic        err_q;
  logic [3:0]  hit;
  logic        perm_ok, accept, sample, last, bit_s;

  // perm is a bijection iff its four 2-bit fields cover all four indices
  always_comb begin
    hit = '0;
    for (int i = 0; i < 4; i++) hit[bus.perm[2*i +: 2]] = 1'b1;
  end
  assign perm_ok = &hit;

  assign accept = (state == IDLE) && bus.start;
  assign sample = (state == APPLY) && (scnt == SETTLE_C);
  assign last   = sample && (m == 4'd15);
  assign bit_s  = y0 ^ on_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && perm_ok) state_nxt = APPLY;
      APPLY:   if (last)              state_nxt = DONE;
      DONE:    if (bus.tt_ready)      state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // Config is latched on every IDLE start; on an invalid perm the FSM stays
  // in IDLE so the latched copy is never used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m      <= '0;
      scnt   <= '0;
      perm_q <= '0;
      neg_q  <= '0;
      on_q   <= 1'b0;
      tt_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= accept && !perm_ok;
      if (accept) begin
        perm_q <= bus.perm;
        neg_q  <= bus.neg_mask;
        on_q   <= bus.out_neg;
        m      <= '0;
        scnt   <= '0;
      end
      if (state == APPLY) begin
        if (sample) begin
          scnt    <= '0;
          m       <= m + 4'd1;   // wraps to 0 after the last minterm
          tt_q[m] <= bit_s;
        end else begin
          scnt <= scnt + 3'd1;
        end
      end
    end
  end

`ifdef NPN_TT_ONES_EN
  logic [4:0] ones_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     ones_q <= '0;
    else if (accept)             ones_q <= '0;
    else if (sample && bit_s)    ones_q <= ones_q + 5'd1;
  end
  assign bus.tt_ones = ones_q;
`endif

  // x[i] = m[perm[2i+1:2i]] ^ neg_mask[i], forced to 0 outside APPLY
  for (genvar i = 0; i < 4; i++) begin : g_x
    assign x[i] = (state == APPLY) && (m[perm_q[2*i +: 2]] ^ neg_q[i]);
  end

  assign bus.busy     = (state != IDLE);
  assign bus.tt_valid = (state == DONE);
  assign bus.err      = err_q;
  assign bus.tt       = tt_q;
endmodule

// File: tb/tb_npn_tt_sweeper.sv
module tb_npn_tt_sweeper;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  npn_tt_sweeper_if b1();
  npn_tt_sweeper_if b0();
  logic [3:0]  x1, x0;
  logic [15:0] f1 = '0, f0 = '0;   // netlist under test, indexed by x
  logic        y1, y0;
  assign y1 = f1[x1];
  assign y0 = f0[x0];

  npn_tt_sweeper #(.SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1), .x(x1), .y0(y1));
  npn_tt_sweeper #(.SETTLE(0)) dut0 (.clk(clk), .rst(rst), .bus(b0), .x(x0), .y0(y0));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] f;
    logic [7:0]  perm;
    logic [3:0]  neg;
    logic        on;
    logic [15:0] exp;
  } vec_t;
  vec_t vt[5];

  localparam logic [7:0] ID = 8'b11_10_01_00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference: evaluate the netlist on each NPN-mapped minterm.
  function automatic logic [15:0] ref_tt(input logic [15:0] f, input logic [7:0] p,
                                         input logic [3:0] n, input logic on);
    logic [15:0] r;
    logic [3:0]  mv, xv;
    for (int mm = 0; mm < 16; mm++) begin
      mv = 4'(mm);
      for (int i = 0; i < 4; i++) xv[i] = mv[p[2*i +: 2]] ^ n[i];
      r[mm] = f[xv] ^ on;
    end
    return r;
  endfunction

  function automatic logic [7:0] rand_perm();
    logic [1:0] a[4];
    logic [1:0] t;
    int j;
    for (int i = 0; i < 4; i++) a[i] = 2'(i);
    for (int i = 3; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = a[i]; a[i] = a[j]; a[j] = t;
    end
    return {a[3], a[2], a[1], a[0]};
  endfunction

  task automatic sweep1(input logic [15:0] f, input logic [7:0] p, input logic [3:0] n,
                        input logic on, input bit scramble,
                        output logic [15:0] tt, output logic [4:0] ones, output int lat);
    @(negedge clk);
    f1 = f; b1.perm = p; b1.neg_mask = n; b1.out_neg = on; b1.tt_ready = 1'b1; b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    if (scramble) begin
      b1.perm = 8'($urandom); b1.neg_mask = 4'($urandom); b1.out_neg = 1'($urandom);
    end
    lat = 1;
    while (!b1.tt_valid && lat < 200) begin @(negedge clk); lat++; end
    tt = b1.tt;
    ones = '0;
`ifdef NPN_TT_ONES_EN
    ones = b1.tt_ones;
`endif
    @(negedge clk);
    chk("busy_after_hs", 32'(b1.busy), 0);
    chk("valid_after_hs", 32'(b1.tt_valid), 0);
  endtask

  task automatic sweep0(input logic [15:0] f, input logic [7:0] p, input logic [3:0] n,
                        input logic on, output logic [15:0] tt, output int lat);
    @(negedge clk);
    f0 = f; b0.perm = p; b0.neg_mask = n; b0.out_neg = on; b0.tt_ready = 1'b1; b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    lat = 1;
    while (!b0.tt_valid && lat < 200) begin @(negedge clk); lat++; end
    tt = b0.tt;
    @(negedge clk);
    chk("busy0_after_hs", 32'(b0.busy), 0);
  endtask

  logic [15:0] tt, ttc, f, exp;
  logic [4:0]  ones;
  logic [7:0]  p;
  logic [3:0]  n;
  logic        on;
  int          lat, w;

  initial begin
    vt[0] = '{16'h8888, ID,           4'b0000, 1'b0, 16'h8888};
    vt[1] = '{16'h8888, ID,           4'b0001, 1'b0, 16'h4444};
    vt[2] = '{16'h8888, ID,           4'b0000, 1'b1, 16'h7777};
    vt[3] = '{16'h8888, 8'b11_00_01_10, 4'b0000, 1'b0, 16'hC0C0};
    vt[4] = '{16'hFF00, ID,           4'b0000, 1'b0, 16'hFF00};

    b1.start = 0; b1.perm = ID; b1.neg_mask = 0; b1.out_neg = 0; b1.tt_ready = 1;
    b0.start = 0; b0.perm = ID; b0.neg_mask = 0; b0.out_neg = 0; b0.tt_ready = 1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_x", 32'(x1), 0);
    chk("rst_tt", 32'(b1.tt), 0);
    chk("rst_valid", 32'(b1.tt_valid), 0);
    chk("rst_busy", 32'(b1.busy), 0);
    chk("rst_err", 32'(b1.err), 0);
`ifdef NPN_TT_ONES_EN
    chk("rst_ones", 32'(b1.tt_ones), 0);
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // directed vectors
    foreach (vt[i]) begin
      sweep1(vt[i].f, vt[i].perm, vt[i].neg, vt[i].on, 1'b0, tt, ones, lat);
      chk($sformatf("vec%0d_tt", i), 32'(tt), 32'(vt[i].exp));
      chk($sformatf("vec%0d_lat", i), lat, 33);
`ifdef NPN_TT_ONES_EN
      chk($sformatf("vec%0d_ones", i), 32'(ones), $countones(vt[i].exp));
`endif
    end

    // non-bijective perm: single err pulse, nothing else moves
    @(negedge clk);
    b1.perm = 8'b11_10_01_10; b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0; b1.perm = ID;
    chk("err_pulse", 32'(b1.err), 1);
    chk("err_busy", 32'(b1.busy), 0);
    chk("err_x", 32'(x1), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("err_clear", 32'(b1.err), 0);
      chk("err_no_valid", 32'(b1.tt_valid), 0);
      chk("err_idle", 32'(b1.busy), 0);
    end

    // backpressure with start pulses during the wait
    @(negedge clk);
    f1 = 16'h8888; b1.perm = ID; b1.neg_mask = 0; b1.out_neg = 0;
    b1.tt_ready = 1'b0; b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    w = 0;
    while (!b1.tt_valid && w < 200) begin @(negedge clk); w++; end
    chk("bp_valid_seen", 32'(b1.tt_valid), 1);
    ttc = b1.tt;
    chk("bp_tt", 32'(ttc), 32'h8888);
    for (int k = 0; k < 5; k++) begin
      b1.start = ~b1.start;
      @(negedge clk);
      chk("bp_hold_valid", 32'(b1.tt_valid), 1);
      chk("bp_hold_tt", 32'(b1.tt), 32'(ttc));
      chk("bp_hold_busy", 32'(b1.busy), 1);
    end
    b1.start = 1'b1; b1.tt_ready = 1'b1;   // handshake and start together
    @(negedge clk);
    b1.start = 1'b0;
    chk("bp_hs_valid", 32'(b1.tt_valid), 0);
    chk("bp_hs_busy", 32'(b1.busy), 0);
    chk("bp_tt_kept", 32'(b1.tt), 32'h8888);
    @(negedge clk);
    chk("bp_no_restart", 32'(b1.busy), 0);

    // reset in the middle of minterm 7
    @(negedge clk);
    f1 = 16'h8888; b1.perm = ID; b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    repeat (14) @(negedge clk);
    chk("mid_x_m7", 32'(x1), 7);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_x", 32'(x1), 0);
    chk("mid_rst_tt", 32'(b1.tt), 0);
    chk("mid_rst_busy", 32'(b1.busy), 0);
    chk("mid_rst_valid", 32'(b1.tt_valid), 0);
    chk("mid_rst_err", 32'(b1.err), 0);
`ifdef NPN_TT_ONES_EN
    chk("mid_rst_ones", 32'(b1.tt_ones), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    sweep1(16'hFF00, ID, 4'b0000, 1'b0, 1'b0, tt, ones, lat);
    chk("post_rst_tt", 32'(tt), 32'hFF00);
    chk("post_rst_lat", lat, 33);
`ifdef NPN_TT_ONES_EN
    chk("post_rst_ones", 32'(ones), 8);
`endif

    // random NPN sweeps, config scrambled after acceptance
    for (int r = 0; r < 20; r++) begin
      f = 16'($urandom); p = rand_perm(); n = 4'($urandom); on = 1'($urandom);
      exp = ref_tt(f, p, n, on);
      sweep1(f, p, n, on, 1'b1, tt, ones, lat);
      chk($sformatf("rnd%0d_tt", r), 32'(tt), 32'(exp));
      chk($sformatf("rnd%0d_lat", r), lat, 33);
`ifdef NPN_TT_ONES_EN
      chk($sformatf("rnd%0d_ones", r), 32'(ones), $countones(exp));
`endif
    end

    // SETTLE=0 instance
    sweep0(16'h6996, ID, 4'b0000, 1'b0, tt, lat);
    chk("s0_parity_tt", 32'(tt), 32'h6996);
    chk("s0_parity_lat", lat, 17);
    for (int r = 0; r < 5; r++) begin
      f = 16'($urandom); p = rand_perm(); n = 4'($urandom); on = 1'($urandom);
      sweep0(f, p, n, on, tt, lat);
      chk($sformatf("s0_rnd%0d_tt", r), 32'(tt), 32'(ref_tt(f, p, n, on)));
      chk($sformatf("s0_rnd%0d_lat", r), lat, 17);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/npn_tt_sweeper.md
Name: npn_tt_sweeper

Overview:
- Sequencer that drives the four inputs (x0..x3) of an external 4-input exact-synthesis function netlist through all 16 minterms and samples its single output y0.
- Collects the result as a 16-bit truth table, with a configurable input permutation, input negation and output negation (the NPN transform).
- Used as the self-check and characterisation front end for the generated 4-input netlists; result is returned over a valid/ready handshake.

Parameters:
- SETTLE, default 1: extra wait cycles per minterm before sampling y0 (range 0..7); each minterm occupies SETTLE+1 cycles.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a sweep; accepted only in IDLE
- perm  input  8  input permutation; x[i] is taken from minterm bit perm[2i+1:2i]
- neg_mask  input  4  per-input negation, applied after permutation
- out_neg  input  1  invert sampled y0
- x  output  4  drives x0..x3 of the function netlist (x[0]=x0)
- y0  input  1  function netlist output
- busy  output  1  high from start acceptance until the result is consumed
- err  output  1  one-cycle pulse when perm is not a bijection
- tt  output  16  truth table; tt[m] = sampled value for minterm m
- tt_valid  output  1  result valid
- tt_ready  input  1  consumer accepts result

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: x=0, tt=0, tt_valid=0, busy=0, err=0, state IDLE, minterm counter m=0, settle counter 0.
- Reset asserted mid-sweep or in DONE aborts immediately to the reset values. A partial tt is never presented.
- Mapping for minterm m (4-bit): x[i] = m[perm[2i+1:2i]] ^ neg_mask[i]. Sample is y0 ^ out_neg.
- Identity configuration is perm=8'b11_10_01_00, neg_mask=0, out_neg=0.
- FSM states: IDLE, APPLY, DONE.
- IDLE:
  - x held at 0.
  - start=1 at edge k latches perm, neg_mask and out_neg.
  - Config changes after acceptance are ignored until the next acceptance.
  - If the latched perm has any duplicate index: err=1 for cycle k+1 only, busy stays 0, state stays IDLE.
  - Otherwise: busy=1, m=0, go to APPLY.
- APPLY:
  - x shows minterm m from cycle k+1 onward.
  - Each minterm is held for SETTLE+1 cycles.
  - y0 is sampled on the last cycle of the minterm and written to tt[m].
  - After the sample, m increments. After m=15 is sampled, go to DONE.
  - x returns to 0 in DONE.
- DONE:
  - tt_valid=1 from cycle k+1+16*(SETTLE+1) onward.
  - tt is stable while tt_valid=1.
  - On tt_valid&&tt_ready at an edge: tt_valid=0, busy=0, go to IDLE. tt keeps its value until the next sweep's first sample.
  - The next start is accepted no earlier than the cycle after the handshake.
- start while busy (APPLY or DONE): ignored, not queued.
- start and the tt handshake in the same cycle: the handshake completes and start is ignored.
- tt_ready while tt_valid=0: no effect.
- tt bits are overwritten in place during a sweep. tt is defined only when tt_valid=1.
- Latency, SETTLE=1: start edge to tt_valid high = 33 cycles.

Optional Feature:
- Macro: NPN_TT_ONES_EN.
- Defined:
  - Adds output port tt_ones (5 bits), an incremental count of 1-samples.
  - Cleared on start acceptance; +1 at each sample whose value (after out_neg) is 1.
  - Valid and stable with tt_valid; range 0..16; reset value 0.
  - Must equal popcount(tt) whenever tt_valid=1.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Bench function y0=x0&x1, identity config, SETTLE=1, tt_ready=1 → tt=16'h8888, tt_valid at start+33 cycles, busy low the following cycle, tt_ones=4.
- Same function, neg_mask=4'b0001 → tt=16'h4444. Then out_neg=1 with neg_mask=0 → tt=16'h7777, tt_ones=12.
- perm=8'b11_00_01_10 (x0 from m[2], x2 from m[0]) with y0=x0&x1 → tt=16'hC0C0. Then perm=8'b11_10_01_10 → single-cycle err pulse, busy=0, x stays 0, no tt_valid.
- Backpressure: tt_ready=0 for 5 cycles after tt_valid, with start pulsed during the wait → tt and tt_valid stable, no new sweep starts, and the handshake completes when tt_ready rises.
- Reset asserted while m=7 in APPLY, then a fresh start with y0=x3 → all outputs 0 immediately on reset, and the fresh sweep gives tt=16'hFF00 with no residue.
- SETTLE=0 build with y0=x0^x1^x2^x3 → tt=16'h6996, tt_valid at start+17 cycles.
